// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and colour from a VGA timing stream; pixels are emitted only after a full frame verifies.
// Optional: define VGA_DEC_ERR_CNT_EN to add a saturating 8-bit err_count output.
module vga_sync_decoder #(
    parameter int H_TOTAL  = 800,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       vga_blank,
    input  logic [7:0] vga_r,
    input  logic [7:0] vga_g,
    input  logic [7:0] vga_b,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic [7:0] px_r,
    output logic [7:0] px_g,
    output logic [7:0] px_b,
    output logic       px_valid,
    output logic       frame_done,
    output logic       locked,
    output logic       sync_err
`ifdef VGA_DEC_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [9:0] H_TOT    = 10'(H_TOTAL);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_TOT    = 10'(V_TOTAL);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t     state_q, state_d;
    logic       hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, blank_s1_q, blank_s1_d;
    logic [7:0] r_s1_q, r_s1_d, g_s1_q, g_s1_d, b_s1_q, b_s1_d;
    logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0] hper_q, hper_d, vper_q, vper_d, xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic [9:0] px_x_q, px_x_d, px_y_q, px_y_d;
    logic [7:0] px_r_q, px_r_d, px_g_q, px_g_d, px_b_q, px_b_d;
    logic       px_valid_q, px_valid_d, frame_done_q, frame_done_d;
    logic       sync_err_q, sync_err_d;

    logic       hs_fall, vs_fall, line_bad, frame_bad, pix;
    logic [9:0] x_base, y_line, v_line;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    assign hs_fall = hs_prev_q & ~hs_s1_q;
    assign vs_fall = vs_prev_q & ~vs_s1_q;

    // Line and frame results include the hs edge of this cycle, so coincident edges see hs effects first.
    assign line_bad  = (hper_q != H_TOT) || ((xcnt_q != 10'd0) && (xcnt_q != H_ACT));
    assign y_line    = (hs_fall && (xcnt_q != 10'd0)) ? sat_inc(ycnt_q) : ycnt_q;
    assign v_line    = hs_fall ? sat_inc(vper_q) : vper_q;
    assign frame_bad = (v_line != V_TOT) || (y_line != V_ACT);
    assign x_base    = hs_fall ? 10'd0 : xcnt_q;
    assign pix       = (state_q == LOCKED) && blank_s1_q;

    always_comb begin
        hs_s1_d      = vga_hs;
        vs_s1_d      = vga_vs;
        blank_s1_d   = vga_blank;
        r_s1_d       = vga_r;
        g_s1_d       = vga_g;
        b_s1_d       = vga_b;
        hs_prev_d    = hs_s1_q;
        vs_prev_d    = vs_s1_q;
        hper_d       = hs_fall ? 10'd1 : sat_inc(hper_q);
        xcnt_d       = blank_s1_q ? sat_inc(x_base) : x_base;
        ycnt_d       = vs_fall ? 10'd0 : y_line;
        vper_d       = vs_fall ? 10'd0 : v_line;
        state_d      = state_q;
        sync_err_d   = 1'b0;
        px_valid_d   = pix;
        frame_done_d = pix && (x_base == H_LAST) && (ycnt_q == V_LAST);
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        px_r_d       = px_r_q;
        px_g_d       = px_g_q;
        px_b_d       = px_b_q;

        case (state_q)
            SEARCH: begin
                if (vs_fall) state_d = ALIGN;
            end
            ALIGN: begin
                if (hs_fall && line_bad) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    state_d = frame_bad ? SEARCH : LOCKED;
                end
            end
            LOCKED: begin
                if ((hs_fall && line_bad) || (vs_fall && frame_bad) || (xcnt_q > H_ACT)) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        if (pix) begin
            px_x_d = x_base;
            px_y_d = ycnt_q;
            px_r_d = r_s1_q;
            px_g_d = g_s1_q;
            px_b_d = b_s1_q;
        end
    end

    // Sync bits reset high so a low level after reset is not mistaken for a falling edge.
    always_ff @(posedge clk_25) begin
        if (!rst) begin
            state_q      <= SEARCH;
            hs_s1_q      <= 1'b1;
            vs_s1_q      <= 1'b1;
            blank_s1_q   <= 1'b0;
            r_s1_q       <= '0;
            g_s1_q       <= '0;
            b_s1_q       <= '0;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            hper_q       <= '0;
            vper_q       <= '0;
            xcnt_q       <= '0;
            ycnt_q       <= '0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            px_r_q       <= '0;
            px_g_q       <= '0;
            px_b_q       <= '0;
            px_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_s1_q      <= hs_s1_d;
            vs_s1_q      <= vs_s1_d;
            blank_s1_q   <= blank_s1_d;
            r_s1_q       <= r_s1_d;
            g_s1_q       <= g_s1_d;
            b_s1_q       <= b_s1_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hper_q       <= hper_d;
            vper_q       <= vper_d;
            xcnt_q       <= xcnt_d;
            ycnt_q       <= ycnt_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            px_r_q       <= px_r_d;
            px_g_q       <= px_g_d;
            px_b_q       <= px_b_d;
            px_valid_q   <= px_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign px_r       = px_r_q;
    assign px_g       = px_g_q;
    assign px_b       = px_b_q;
    assign px_valid   = px_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == LOCKED);

`ifdef VGA_DEC_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (sync_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk_25) begin
        if (!rst) err_count_q <= '0;
        else      err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 12x6 timing (4x3 visible).
// Define VGA_DEC_ERR_CNT_EN to also exercise the err_count output.
module tb_vga_sync_decoder;

    localparam int HT       = 12;
    localparam int HA       = 4;
    localparam int VT       = 6;
    localparam int VA       = 3;
    localparam int HS_START = 8;
    localparam int HS_END   = 11;
    localparam int VS_LINE  = 4;

    logic       clk_25 = 1'b0;
    logic       rst;
    logic       vga_hs, vga_vs, vga_blank;
    logic [7:0] vga_r, vga_g, vga_b;
    logic [9:0] px_x, px_y;
    logic [7:0] px_r, px_g, px_b;
    logic       px_valid, frame_done, locked, sync_err;
`ifdef VGA_DEC_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    int pxCount = 0;
    int fdCount = 0;
    int errSeen = 0;
    int errV = -1;
    int curH = 0;
    int curV = 0;
    int d1H = 0, d1V = 0, d2H = 0, d2V = 0;
    logic d1Blank = 1'b0, d2Blank = 1'b0;

    always #5 clk_25 = ~clk_25;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA)
    ) dut (
        .clk_25(clk_25), .rst(rst),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .px_x(px_x), .px_y(px_y), .px_r(px_r), .px_g(px_g), .px_b(px_b),
        .px_valid(px_valid), .frame_done(frame_done), .locked(locked),
        .sync_err(sync_err)
`ifdef VGA_DEC_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // One pixel clock of the stream; inputs change on the falling edge.
    task automatic applyStimulus(input int h, input int v, input logic rstVal);
        @(negedge clk_25);
        rst       = rstVal;
        curH      = h;
        curV      = v;
        vga_hs    = !(h >= HS_START && h < HS_END);
        vga_vs    = (v != VS_LINE);
        vga_blank = (h < HA) && (v < VA);
        vga_r     = vga_blank ? 8'(h) : 8'd0;
        vga_g     = vga_blank ? 8'(v) : 8'd0;
        vga_b     = vga_blank ? 8'(h ^ v) : 8'd0;
    endtask

    task automatic driveLines(input int first, input int last, input int longLine);
        for (int v = first; v <= last; v++) begin
            for (int h = 0; h < ((v == longLine) ? HT + 1 : HT); h++) applyStimulus(h, v, 1'b1);
        end
    endtask

    task automatic driveFrame(input int nLines, input int longLine);
        driveLines(0, nLines - 1, longLine);
    endtask

    task automatic clearCounts();
        pxCount = 0;
        fdCount = 0;
        errSeen = 0;
        errV    = -1;
    endtask

    task automatic checkFrame(input string tag, input int expPx, input int expFd, input int expErr, input logic expLocked);
        checkOutput({tag, "_px_count"}, pxCount, expPx);
        checkOutput({tag, "_fd_count"}, fdCount, expFd);
        checkOutput({tag, "_err_count"}, errSeen, expErr);
        checkOutput({tag, "_locked"}, locked, expLocked);
    endtask

    // Two-deep history of what was driven, matching the decoder's input-to-output latency.
    always @(posedge clk_25) begin
        d1H     <= curH;
        d1V     <= curV;
        d1Blank <= vga_blank;
        d2H     <= d1H;
        d2V     <= d1V;
        d2Blank <= d1Blank;
    end

    always @(negedge clk_25) begin
        if (px_valid === 1'b1) begin
            pxCount++;
            checkOutput("px_src_visible", d2Blank, 1'b1);
            checkOutput("px_x", px_x, d2H);
            checkOutput("px_y", px_y, d2V);
            checkOutput("px_rgb", {px_r, px_g, px_b}, {8'(d2H), 8'(d2V), 8'(d2H ^ d2V)});
        end
        if (frame_done === 1'b1) begin
            fdCount++;
            checkOutput("fd_xy", {px_x, px_y}, {10'(HA - 1), 10'(VA - 1)});
            checkOutput("fd_valid", px_valid, 1'b1);
        end
        if (sync_err === 1'b1) begin
            errSeen++;
            errV = curV;
        end
    end

    initial begin
        rst = 1'b0;
        repeat (3) applyStimulus(HT - 1, VT - 1, 1'b0);
        checkOutput("rst_px_valid", px_valid, 1'b0);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_sync_err", sync_err, 1'b0);
        checkOutput("rst_frame_done", frame_done, 1'b0);
        checkOutput("rst_px_xy", {px_x, px_y}, 20'd0);
        checkOutput("rst_px_rgb", {px_r, px_g, px_b}, 24'd0);
`ifdef VGA_DEC_ERR_CNT_EN
        checkOutput("rst_err_count", err_count, 8'd0);
`endif

        // Frames 1-2: first vs edge enters ALIGN, second one locks.
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f1", 0, 0, 0, 1'b0);
        clearCounts();
        driveLines(0, VS_LINE - 1, -1);
        checkOutput("f2_pre_vs_locked", locked, 1'b0);
        driveLines(VS_LINE, VT - 1, -1);
        checkFrame("f2", 0, 0, 0, 1'b1);
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f3", HA * VA, 1, 0, 1'b1);

        // Long line 0 is caught at the hs edge that starts line 1.
        clearCounts();
        driveFrame(VT, 0);
        checkFrame("f4_long", 8, 0, 1, 1'b0);
        checkOutput("f4_err_line", errV, 1);
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f5_relock", 0, 0, 0, 1'b1);
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f6", HA * VA, 1, 0, 1'b1);

        // A frame one line short is flagged at the following vs edge.
        clearCounts();
        driveFrame(VT - 1, -1);
        checkFrame("f7_short", HA * VA, 1, 0, 1'b1);
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f8_after_short", HA * VA, 1, 1, 1'b0);
        checkOutput("f8_err_line", errV, VS_LINE);
`ifdef VGA_DEC_ERR_CNT_EN
        checkOutput("f8_err_count", err_count, 8'd2);
`endif
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f9", 0, 0, 0, 1'b0);
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f10", 0, 0, 0, 1'b1);

        // Reset held low for three clocks at the start of line 2.
        clearCounts();
        driveLines(0, 1, -1);
        applyStimulus(0, 2, 1'b0);
        applyStimulus(1, 2, 1'b0);
        checkOutput("mid_rst_px_valid", px_valid, 1'b0);
        checkOutput("mid_rst_locked", locked, 1'b0);
        checkOutput("mid_rst_sync_err", sync_err, 1'b0);
        checkOutput("mid_rst_frame_done", frame_done, 1'b0);
        checkOutput("mid_rst_px_xy", {px_x, px_y}, 20'd0);
        checkOutput("mid_rst_px_rgb", {px_r, px_g, px_b}, 24'd0);
`ifdef VGA_DEC_ERR_CNT_EN
        checkOutput("mid_rst_err_count", err_count, 8'd0);
`endif
        applyStimulus(2, 2, 1'b0);
        for (int h = 3; h < HT; h++) applyStimulus(h, 2, 1'b1);
        driveLines(3, VT - 1, -1);
        checkFrame("f11_rst", 8, 0, 0, 1'b0);
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f12_relock", 0, 0, 0, 1'b1);
        clearCounts();
        driveFrame(VT, -1);
        checkFrame("f13", HA * VA, 1, 0, 1'b1);

`ifdef VGA_DEC_ERR_CNT_EN
        clearCounts();
        for (int i = 0; i < 300; i++) begin
            driveFrame(VT, 0);
            driveFrame(VT, -1);
        end
        checkOutput("sat_err_pulses", errSeen, 300);
        checkOutput("sat_err_count", err_count, 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL provide parameters: H_TOTAL, default 800, clocks per line; H_ACTIVE, default 640, visible pixels per line; V_TOTAL, default 525, lines per frame; V_ACTIVE, default 480, visible lines per frame.
REQ-002 SHALL have port clk_25, input, 1 bit: pixel clock; every register updates on its rising edge only.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have ports vga_hs and vga_vs, input, 1 bit each: sync pulses, active-low.
REQ-005 SHALL have port vga_blank, input, 1 bit: high means a visible pixel.
REQ-006 SHALL have ports vga_r, vga_g and vga_b, input, 8 bits each: pixel colour.
REQ-007 SHALL have ports px_x and px_y, output, 10 bits each: recovered pixel coordinate.
REQ-008 SHALL have ports px_r, px_g and px_b, output, 8 bits each: captured colour.
REQ-009 SHALL have port px_valid, output, 1 bit: pixel strobe.
REQ-010 SHALL have port frame_done, output, 1 bit: pulse when the last visible pixel of a frame is output.
REQ-011 SHALL have port locked, output, 1 bit: timing locked.
REQ-012 SHALL have port sync_err, output, 1 bit: pulse on a timing violation.

Function
REQ-013 SHALL register all inputs once (stage S1) and detect falling edges of vga_hs and vga_vs by comparing S1 with the previous S1 value.
REQ-014 SHALL count clocks between consecutive hs falling edges in a 10-bit hper counter, saturating at 1023.
REQ-015 SHALL count hs falling edges between consecutive vs falling edges in a 10-bit vper counter, saturating at 1023.
REQ-016 SHALL increment a 10-bit xcnt on each S1 cycle with blank high, clear it at each hs falling edge, and saturate it at 1023.
REQ-017 SHALL increment a 10-bit ycnt at an hs falling edge only if the preceding line had xcnt > 0, and clear ycnt at each vs falling edge.
REQ-018 SHALL implement a state machine with states SEARCH, ALIGN and LOCKED; reset state is SEARCH.
REQ-019 SEARCH: SHALL move to ALIGN on a vs falling edge.
REQ-020 ALIGN: at each hs falling edge, SHALL return to SEARCH if hper != H_TOTAL or the line's xcnt is not 0 or H_ACTIVE.
REQ-021 ALIGN: at the next vs falling edge, SHALL move to LOCKED if vper == V_TOTAL and the visible-line count == V_ACTIVE, else to SEARCH.
REQ-022 LOCKED: SHALL pulse sync_err for 1 cycle and enter SEARCH on any REQ-020 or REQ-021 violation, or on xcnt exceeding H_ACTIVE.
REQ-023 SHALL set locked = 1 only in LOCKED.
REQ-024 In LOCKED with S1 blank high, SHALL on the next clock assert px_valid with px_x = xcnt before increment, px_y = ycnt, and px_r/g/b = S1 colour; total latency from input pins is 2 clocks.
REQ-025 SHALL drive px_valid = 0 outside LOCKED; px_x, px_y and px_r/g/b hold their last values when px_valid = 0.
REQ-026 SHALL pulse frame_done in the same cycle as px_valid when px_x == H_ACTIVE-1 and px_y == V_ACTIVE-1.
REQ-027 On simultaneous hs and vs falling edges, SHALL evaluate the hs checks first, then the vs checks, and clear ycnt and vper.
REQ-028 SHALL treat a vs falling edge before line V_TOTAL as a violation in ALIGN or LOCKED.

Reset
REQ-029 SHALL, when rst is low at a clock edge, clear all counters, set state = SEARCH, set the S1 sync bits to 1 and S1 blank to 0, and drive all outputs to 0.
REQ-030 SHALL allow reset asserted mid-frame to abort immediately, with no pixel output until a full frame has been re-verified.

Configuration
REQ-031 SHALL, when VGA_DEC_ERR_CNT_EN is defined, add output err_count (8 bits), incremented on each sync_err, saturating at 255, and cleared by reset.
REQ-032 SHALL, when VGA_DEC_ERR_CNT_EN is undefined, omit the err_count port and its logic entirely.

Verification
REQ-033 SHALL cover: nominal 640x480 timing stream, 3 frames -> locked = 1 at the 2nd vs falling edge; 307200 px_valid pulses per frame; frame_done once per frame at (639,479).
REQ-034 SHALL cover: pixel colour = {x[7:0], y[7:0], x[7:0]^y[7:0]} -> every px_r/g/b matches the value sent 2 clocks earlier, and px_x/px_y are correct.
REQ-035 SHALL cover: one line of 801 clocks in locked frame 3 -> sync_err pulse at the following hs edge, locked = 0, re-lock after 2 good vs edges.
REQ-036 SHALL cover: frame of 524 lines -> sync_err, locked = 0, and err_count = 1 with VGA_DEC_ERR_CNT_EN.
REQ-037 SHALL cover: rst held low 3 cycles at line 200 -> all outputs 0 the cycle after the edge, px_valid = 0 until re-lock.
REQ-038 SHALL cover: 300 forced errors with VGA_DEC_ERR_CNT_EN -> err_count saturates at 255.
